pipe_retire_monitor: RTL and testbench
======================================

# pipe_retire_monitor

Run-control and retirement monitor for the Y86-64 pipelined core. Observes the writeback stage every cycle, counts cycles and retired instructions, and detects halt, fault and watchdog timeout. Keeps a circular trace of the most recent retirements for the bench to read. It sits beside the pipeline wrapper and replaces ad-hoc `$monitor` printing and fixed-delay `$finish` with a parametrised, self-terminating harness.

## Interface
Parameters:
- DATA_W, 64, width of valE/valM datapath values
- DEPTH, 16, trace entries; power of two, ≥2
- CNT_W, 32, width of cycle and retire counters
- TIMEOUT, 1000, watchdog limit in cycles; 0 disables the watchdog

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- W_icode  in  4  writeback-stage icode
- W_stat  in  2  writeback-stage status: 0=AOK, 1=HLT, 2=ADR, 3=INS
- W_dstE  in  4  writeback destination E (4'hF = none)
- W_valE  in  DATA_W  writeback valE
- trace_idx  in  log2(DEPTH)  trace read index; 0 = most recent entry
- trace_data  out  8+DATA_W  {icode, dstE, valE} of the selected entry
- trace_count  out  log2(DEPTH)+1  valid entries, saturates at DEPTH
- cycle_cnt  out  CNT_W  cycles spent in RUN
- retire_cnt  out  CNT_W  instructions retired
- state  out  2  0=RUN, 1=HALTED, 2=FAULT, 3=TIMEOUT
- done  out  1  high in any state other than RUN

## Operation
- Retirement: a cycle in RUN with W_icode != 4'h1 (nop/bubble) and W_stat ∈ {AOK, HLT}. Real nop instructions are therefore not counted.
- State machine, one transition per cycle:
  - RUN → HALTED when W_stat == HLT. The halt instruction counts as retired and is traced.
  - RUN → FAULT when W_stat ∈ {ADR, INS}. The faulting instruction is not counted and not traced.
  - RUN → TIMEOUT when TIMEOUT != 0, cycle_cnt == TIMEOUT−1 and W_stat == AOK.
  - HALTED, FAULT and TIMEOUT are terminal. Only rst_n leaves them.
- Precedence in the same cycle: HLT/fault beats timeout. The status seen on the terminating edge decides the state.
- cycle_cnt increments on every RUN edge, including the terminating edge. retire_cnt increments on each retirement.
- Both counters saturate at all-ones and never wrap. Both freeze in terminal states.
- Trace is written only on retirement:
  - The write pointer advances modulo DEPTH and overwrites the oldest entry when full.
  - trace_data = entry at (wr_ptr − 1 − trace_idx) mod DEPTH.
  - When trace_idx ≥ trace_count, trace_data is 0.
- All outputs are registered state or combinational decode of it. Nothing depends combinationally on W_* inputs.

## Timing
- Reset (async assert, sync release) drives every output to 0: state=RUN, done=0, both counters 0, trace_count 0, write pointer 0, trace_data 0.
- Reset mid-run clears everything immediately, independent of clk.
- Latency: a retirement sampled on edge N is visible in retire_cnt, trace_count and trace_data (idx 0) after edge N. State change and done also appear after the sampling edge.
- trace_idx → trace_data is a combinational read of the registered trace, settling in the same cycle.

## Configuration
- RETIRE_TRACE_EN defined: trace storage, write pointer, trace_count and trace_data are implemented as above.
- Not defined: no trace storage is built. trace_data and trace_count are tied to 0. Counters, state machine and done are unchanged.

## Test plan
- Reset then 5 retirements (icode 3, dstE 0..4, valE 10..14), then HLT on W_stat → state=1, done=1, retire_cnt=6, cycle_cnt=6, trace idx0 = {icode 0, dstE F, valE of halt cycle}, idx1 valE=14.
- Interleave bubbles (icode 1) with 3 retirements, then INS → state=2, retire_cnt=3, trace_count=3, faulting entry absent. Further inputs change nothing.
- TIMEOUT=8 with W_stat=AOK constant → state=3 after 8th edge, cycle_cnt=8. HLT arriving on the 8th edge instead → state=1.
- DEPTH=4 with 6 retirements, valE 1..6 → trace_count=4; idx0..3 = 6,5,4,3; idx trace_count behaviour checked at count 2 (idx2 → 0).
- CNT_W=4, TIMEOUT=0, 20 retirements → retire_cnt=15 and cycle_cnt=15, both held. Assert rst_n low mid-cycle → all outputs 0 before the next edge.
- Build without RETIRE_TRACE_EN → trace_data=0 and trace_count=0 throughout scenario 1; counters and state identical.

Source files
------------

// File: rtl/pipe_retire_monitor.sv
// rtl/pipe_retire_monitor.sv - Y86-64 writeback run-control, retirement counters and trace ring
// Optional trace storage is built when RETIRE_TRACE_EN is defined.
module pipe_retire_monitor #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  W_icode,
    input  logic [1:0]                  W_stat,
    input  logic [3:0]                  W_dstE,
    input  logic [DATA_W-1:0]           W_valE,
    input  logic [$clog2(DEPTH)-1:0]    trace_idx,
    output logic [7+DATA_W:0]           trace_data,
    output logic [$clog2(DEPTH):0]      trace_count,
    output logic [CNT_W-1:0]            cycle_cnt,
    output logic [CNT_W-1:0]            retire_cnt,
    output logic [1:0]                  state,
    output logic                        done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [1:0] ST_AOK = 2'd0;
    localparam logic [1:0] ST_HLT = 2'd1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_HALTED  = 2'd1,
        S_FAULT   = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             retire;
    logic             timeout_hit;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] retire_q;

    assign timeout_hit = (TIMEOUT != 0) && (cycle_q == TO_LAST);

    // Halt/fault status wins over the watchdog on the same edge.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        if (state_q == S_RUN) begin
            retire = (W_icode != 4'h1) && ((W_stat == ST_AOK) || (W_stat == ST_HLT));
            if (W_stat == ST_HLT) begin
                state_d = S_HALTED;
            end else if (W_stat != ST_AOK) begin
                state_d = S_FAULT;
            end else if (timeout_hit) begin
                state_d = S_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_RUN) && (cycle_q != '1)) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (retire && (retire_q != '1)) begin
                retire_q <= retire_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
    assign state      = state_q;
    assign done       = (state_q != S_RUN);

`ifdef RETIRE_TRACE_EN
    logic [7+DATA_W:0] mem [DEPTH];
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W:0]    count_q;
    logic [IDX_W-1:0]  rd_addr;

    always_ff @(posedge clk) begin
        if (retire) begin
            mem[wr_ptr] <= {W_icode, W_dstE, W_valE};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (retire) begin
            wr_ptr <= wr_ptr + IDX_W'(1);
            if (count_q != (IDX_W+1)'(DEPTH)) begin
                count_q <= count_q + (IDX_W+1)'(1);
            end
        end
    end

    // Index 0 is the newest entry; slots never written are masked by count.
    assign rd_addr     = wr_ptr - IDX_W'(1) - trace_idx;
    assign trace_data  = ({1'b0, trace_idx} < count_q) ? mem[rd_addr] : '0;
    assign trace_count = count_q;
`else
    logic unused_trace_inputs;
    assign unused_trace_inputs = ^{W_dstE, W_valE, trace_idx};
    assign trace_data  = '0;
    assign trace_count = '0;
`endif

endmodule

// File: tb/tb_pipe_retire_monitor.sv
// tb/tb_pipe_retire_monitor.sv - scoreboard bench for pipe_retire_monitor (two configurations)
module tb_pipe_retire_monitor;

`ifdef RETIRE_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic [1:0]  stat = 2'd0;
    logic [3:0]  dst = 4'hF;
    logic [63:0] vale = '0;
    logic [1:0]  a_idx = '0;
    logic [3:0]  b_idx = '0;

    logic [71:0] a_td, b_td;
    logic [2:0]  a_tc;
    logic [4:0]  b_tc;
    logic [31:0] a_cc, a_rc;
    logic [3:0]  b_cc, b_rc;
    logic [1:0]  a_st, b_st;
    logic        a_done, b_done;

    always #10 clk = ~clk;

    pipe_retire_monitor #(.DATA_W(64), .DEPTH(4), .CNT_W(32), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .W_icode(icode), .W_stat(stat), .W_dstE(dst), .W_valE(vale),
        .trace_idx(a_idx), .trace_data(a_td), .trace_count(a_tc), .cycle_cnt(a_cc),
        .retire_cnt(a_rc), .state(a_st), .done(a_done)
    );

    pipe_retire_monitor #(.DATA_W(64), .DEPTH(16), .CNT_W(4), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .W_icode(icode), .W_stat(stat), .W_dstE(dst), .W_valE(vale),
        .trace_idx(b_idx), .trace_data(b_td), .trace_count(b_tc), .cycle_cnt(b_cc),
        .retire_cnt(b_rc), .state(b_st), .done(b_done)
    );

    typedef struct {
        logic [1:0]  st;
        logic [31:0] rc;
        logic [31:0] cc;
        logic [2:0]  tc;
        logic [71:0] td;
    } exp_t;

    exp_t        sb[$];
    logic [71:0] m_tr[$];
    logic [1:0]  m_st;
    logic [31:0] m_rc, m_cc;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [71:0] ent(input logic [3:0] ic, input logic [3:0] d, input logic [63:0] v);
        return {ic, d, v};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of dut_a (DEPTH 4, TIMEOUT 8); expectation queued at drive time.
    task automatic step(input logic [3:0] ic, input logic [1:0] s, input logic [3:0] d, input logic [63:0] v);
        exp_t       e;
        logic [1:0] nst;
        icode = ic; stat = s; dst = d; vale = v;
        if (m_st == 2'd0) begin
            nst = 2'd0;
            if (s == 2'd1) nst = 2'd1;
            else if (s >= 2'd2) nst = 2'd2;
            else if (m_cc == 32'd7) nst = 2'd3;
            m_cc = m_cc + 1;
            if ((ic != 4'h1) && (s <= 2'd1)) begin
                m_rc = m_rc + 1;
                m_tr.push_front(ent(ic, d, v));
                if (m_tr.size() > 4) void'(m_tr.pop_back());
            end
            m_st = nst;
        end
        e.st = m_st;
        e.rc = m_rc;
        e.cc = m_cc;
        e.tc = TR ? 3'(m_tr.size()) : 3'd0;
        e.td = (TR && (m_tr.size() > 0)) ? m_tr[0] : 72'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("state", a_st, e.st);
        chk("done", a_done, (e.st != 2'd0));
        chk("retire_cnt", a_rc, e.rc);
        chk("cycle_cnt", a_cc, e.cc);
        chk("trace_count", a_tc, e.tc);
        chk("trace_idx0", a_td, e.td);
    endtask

    task automatic tchk(input string tag, input logic [1:0] idx, input logic [71:0] exp);
        a_idx = idx;
        #1;
        chk(tag, a_td, TR ? exp : 72'd0);
        a_idx = 2'd0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        icode = 4'h1; stat = 2'd0; dst = 4'hF; vale = '0; a_idx = '0; b_idx = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_st = 2'd0; m_rc = '0; m_cc = '0;
        m_tr.delete();
    endtask

    initial begin
        // Scenario 1: five retirements then halt
        do_reset();
        chk("rst_state", a_st, 2'd0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_cycle", a_cc, 32'd0);
        chk("rst_retire", a_rc, 32'd0);
        chk("rst_tcount", a_tc, 3'd0);
        chk("rst_tdata", a_td, 72'd0);
        for (int i = 0; i < 5; i++) step(4'h3, 2'd0, 4'(i), 64'(10 + i));
        step(4'h0, 2'd1, 4'hF, 64'd99);
        chk("s1_state", a_st, 2'd1);
        chk("s1_retire", a_rc, 32'd6);
        chk("s1_cycle", a_cc, 32'd6);
        tchk("s1_idx0", 2'd0, ent(4'h0, 4'hF, 64'd99));
        tchk("s1_idx1", 2'd1, ent(4'h3, 4'h4, 64'd14));
        chk("s1b_state", b_st, 2'd1);
        chk("s1b_retire", b_rc, 4'd6);
        chk("s1b_cycle", b_cc, 4'd6);
        step(4'h3, 2'd0, 4'h2, 64'd77);

        // Scenario 2: bubbles interleaved, then invalid instruction
        do_reset();
        step(4'h1, 2'd0, 4'hF, 64'd0);
        step(4'h2, 2'd0, 4'h1, 64'd21);
        step(4'h1, 2'd0, 4'hF, 64'd0);
        step(4'h2, 2'd0, 4'h1, 64'd22);
        step(4'h2, 2'd0, 4'h1, 64'd23);
        step(4'h5, 2'd3, 4'h2, 64'd55);
        chk("s2_state", a_st, 2'd2);
        chk("s2_retire", a_rc, 32'd3);
        tchk("s2_idx0", 2'd0, ent(4'h2, 4'h1, 64'd23));
        step(4'h3, 2'd0, 4'h3, 64'd5);
        step(4'h0, 2'd1, 4'hF, 64'd6);

        // Scenario 3: watchdog fires on the 8th edge; halt on the 8th edge wins
        do_reset();
        for (int i = 0; i < 8; i++) step(4'h3, 2'd0, 4'h0, 64'(i));
        chk("s3_state", a_st, 2'd3);
        chk("s3_cycle", a_cc, 32'd8);
        do_reset();
        for (int i = 0; i < 7; i++) step(4'h3, 2'd0, 4'h0, 64'(i));
        step(4'h0, 2'd1, 4'hF, 64'd7);
        chk("s3b_state", a_st, 2'd1);

        // Scenario 4: ring wrap with DEPTH 4
        do_reset();
        step(4'h3, 2'd0, 4'h0, 64'd1);
        step(4'h3, 2'd0, 4'h0, 64'd2);
        tchk("s4_idx2_empty", 2'd2, 72'd0);
        tchk("s4_idx1", 2'd1, ent(4'h3, 4'h0, 64'd1));
        for (int v = 3; v <= 6; v++) step(4'h3, 2'd0, 4'h0, 64'(v));
        for (int k = 0; k < 4; k++) tchk("s4_wrap", 2'(k), ent(4'h3, 4'h0, 64'(6 - k)));

        // Scenario 5: 4-bit counters saturate, then async reset mid-cycle
        do_reset();
        for (int i = 0; i < 20; i++) step(4'h3, 2'd0, 4'(i), 64'(i));
        chk("s5_retire", b_rc, 4'd15);
        chk("s5_cycle", b_cc, 4'd15);
        chk("s5_state", b_st, 2'd0);
        chk("s5_tcount", b_tc, TR ? 5'd16 : 5'd0);
        chk("s5_tdata", b_td, TR ? ent(4'h3, 4'd3, 64'd19) : 72'd0);
        step(4'h1, 2'd0, 4'hF, 64'd0);
        step(4'h3, 2'd0, 4'h1, 64'd1);
        chk("s5_retire_hold", b_rc, 4'd15);
        chk("s5_cycle_hold", b_cc, 4'd15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_a_state", a_st, 2'd0);
        chk("ar_a_done", a_done, 1'b0);
        chk("ar_a_cnt", {a_cc, a_rc}, 64'd0);
        chk("ar_a_trace", {a_tc, a_td}, 75'd0);
        chk("ar_b_state", b_st, 2'd0);
        chk("ar_b_done", b_done, 1'b0);
        chk("ar_b_cnt", {b_cc, b_rc}, 8'd0);
        chk("ar_b_trace", {b_tc, b_td}, 77'd0);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
